// File: rtl/prio_arb_rr.sv
// prio_arb_rr: N-way request arbiter with a registered grant index and a
// valid/ready output handshake. It runs in fixed-priority mode (lowest index
// wins) or round-robin mode.
//
// Optional feature macro: PRIO_ARB_MASK_EN.
//   When it is defined, the module gets a req_mask input. The effective
//   request vector becomes req & ~req_mask.
//   When it is undefined, the effective request vector is req itself.
module prio_arb_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         gnt_rdy,
`ifdef PRIO_ARB_MASK_EN
    input  logic [N-1:0] req_mask,
`endif
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_oh,
    output logic [W:0]   gnt_pend
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [W-1:0] ptr_reg, ptr_next;
    logic [W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [N-1:0] gnt_oh_reg, gnt_oh_next;
    logic [W:0]   gnt_pend_reg, gnt_pend_next;

    logic [N-1:0] eff_req;
    logic         any_req;
    logic [W-1:0] idx_inc;
    logic [W-1:0] rr_start;
    logic [W-1:0] scan_start;
    logic [N-1:0] rot_req;
    logic [W-1:0] rot_off;
    logic [W:0]   win_sum;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_oh;
    logic [W:0]   pend_cnt;

`ifdef PRIO_ARB_MASK_EN
    assign eff_req = req & ~req_mask;
`else
    assign eff_req = req;
`endif

    assign any_req = |eff_req;

    // The successor of the current grant wraps at N, not at 2^W.
    // This keeps indices N..2^W-1 unreachable.
    assign idx_inc = (gnt_idx_reg == W'(N - 1)) ? '0 : gnt_idx_reg + 1'b1;

    // In IDLE the round-robin search starts at the stored pointer.
    // At an accepting edge it starts just past the grant being retired.
    // Fixed priority is simply a search that always starts at index 0.
    assign rr_start   = (state_reg == IDLE) ? ptr_reg : idx_inc;
    assign scan_start = mode ? rr_start : '0;

    // Rotate the request vector so that the search start lands on bit 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [W:0]   src_sum;
            logic [W-1:0] src_idx;
            assign src_sum = {1'b0, scan_start} + (W+1)'(gi);
            assign src_idx = (src_sum >= (W+1)'(N)) ? W'(src_sum - (W+1)'(N))
                                                    : src_sum[W-1:0];
            assign rot_req[gi] = eff_req[src_idx];
        end
    endgenerate

    // Lowest set bit of the rotated vector = offset of the winner from the start.
    always_comb begin
        rot_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                rot_off = W'(k);
            end
        end
    end

    // Undo the rotation to get the winner index, wrapping modulo N.
    assign win_sum = {1'b0, scan_start} + {1'b0, rot_off};
    assign win_idx = (win_sum >= (W+1)'(N)) ? W'(win_sum - (W+1)'(N))
                                            : win_sum[W-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_oh
            assign win_oh[gi] = (win_idx == W'(gi));
        end
    endgenerate

    // Popcount of the effective request vector. The winner is included in the count.
    always_comb begin
        pend_cnt = '0;
        for (int k = 0; k < N; k++) begin
            pend_cnt = pend_cnt + (W+1)'(eff_req[k]);
        end
    end

    // Next-state logic.
    // A capture happens on any edge in IDLE, or on an accepted edge in GRANT.
    // An unaccepted grant holds every output stable.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        gnt_idx_next  = gnt_idx_reg;
        gnt_oh_next   = gnt_oh_reg;
        gnt_pend_next = gnt_pend_reg;

        // The pointer advances on every completed handshake, in both modes.
        // This lets round-robin resume fairly after a period of fixed mode.
        if (state_reg == GRANT && gnt_rdy) begin
            ptr_next = idx_inc;
        end

        if (state_reg == IDLE || gnt_rdy) begin
            if (any_req) begin
                state_next    = GRANT;
                gnt_idx_next  = win_idx;
                gnt_oh_next   = win_oh;
                gnt_pend_next = pend_cnt;
            end else begin
                // gnt_idx and gnt_pend keep their last values while idle.
                state_next  = IDLE;
                gnt_oh_next = '0;
            end
        end
    end

    // State register. Reset is synchronous and active-low, and it overrides any handshake in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            gnt_idx_reg  <= '0;
            gnt_oh_reg   <= '0;
            gnt_pend_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            gnt_idx_reg  <= gnt_idx_next;
            gnt_oh_reg   <= gnt_oh_next;
            gnt_pend_reg <= gnt_pend_next;
        end
    end

    assign gnt_vld  = (state_reg == GRANT);
    assign gnt_idx  = gnt_idx_reg;
    assign gnt_oh   = gnt_oh_reg;
    assign gnt_pend = gnt_pend_reg;

endmodule

// File: tb/tb_prio_arb_rr.sv
// Testbench for prio_arb_rr.
// An 8-way instance is checked against a transaction-level reference model.
// A 5-way instance is checked on the non-power-of-two wrap.
module tb_prio_arb_rr;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int N5 = 5;
    localparam int W5 = 3;

    logic clk;

    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] req_mask;
    logic         mode;
    logic         gnt_rdy;
    logic         gnt_vld;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_oh;
    logic [W:0]   gnt_pend;

    logic          rst_n5;
    logic [N5-1:0] req5;
    logic [N5-1:0] req_mask5;
    logic          mode5;
    logic          gnt_rdy5;
    logic          gnt_vld5;
    logic [W5-1:0] gnt_idx5;
    logic [N5-1:0] gnt_oh5;
    logic [W5:0]   gnt_pend5;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: is a grant outstanding, its index and count, and the RR pointer.
    bit m_busy;
    int m_idx;
    int m_pend;
    int m_ptr;

    prio_arb_rr #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .gnt_rdy  (gnt_rdy),
`ifdef PRIO_ARB_MASK_EN
        .req_mask (req_mask),
`endif
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .gnt_oh   (gnt_oh),
        .gnt_pend (gnt_pend)
    );

    prio_arb_rr #(.N(N5)) dut5 (
        .clk      (clk),
        .rst_n    (rst_n5),
        .req      (req5),
        .mode     (mode5),
        .gnt_rdy  (gnt_rdy5),
`ifdef PRIO_ARB_MASK_EN
        .req_mask (req_mask5),
`endif
        .gnt_vld  (gnt_vld5),
        .gnt_idx  (gnt_idx5),
        .gnt_oh   (gnt_oh5),
        .gnt_pend (gnt_pend5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one clock edge to the model, using the inputs the DUT is about to sample.
    task automatic model_edge();
        logic [N-1:0] eff;
        int start;
        int w;
        int i;
`ifdef PRIO_ARB_MASK_EN
        eff = req & ~req_mask;
`else
        eff = req;
`endif
        if (!rst_n) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_pend = 0;
            m_ptr  = 0;
        end else if (!(m_busy && !gnt_rdy)) begin
            start = m_busy ? (m_idx + 1) % N : m_ptr;
            if (m_busy) m_ptr = (m_idx + 1) % N;
            if (!mode) start = 0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                i = (start + k) % N;
                if (w < 0 && eff[i]) w = i;
            end
            if (w >= 0) begin
                m_busy = 1'b1;
                m_idx  = w;
                m_pend = $countones(eff);
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    function automatic logic [1+W+N+W:0] exp_vec();
        logic [N-1:0] oh;
        oh = m_busy ? (N'(1) << m_idx) : '0;
        return {m_busy, W'(m_idx), oh, (W+1)'(m_pend)};
    endfunction

    function automatic logic [1+W+N+W:0] obs_vec();
        return {gnt_vld, gnt_idx, gnt_oh, gnt_pend};
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; mode = 1'b0; gnt_rdy = 1'b0; req_mask = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (obs_vec() !== '0) begin
                $display("FAIL reset_outputs cyc=%0d got {vld,idx,oh,pend}=%h want 0", cyc, obs_vec());
                n_err++;
            end
        end
        rst_n = 1'b1; req = 8'h00;
        step();
        n_cmp++;
        if (gnt_vld !== 1'b0 || obs_vec() !== exp_vec()) begin
            $display("FAIL idle_after_reset cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            n_err++;
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; req = 8'b1010_0100; gnt_rdy = 1'b1;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd2 || gnt_oh !== 8'h04 || gnt_pend !== 4'd3) begin
            $display("FAIL fixed_lowest cyc=%0d got idx=%0d oh=%h pend=%0d want idx=2 oh=04 pend=3",
                     cyc, gnt_idx, gnt_oh, gnt_pend);
            n_err++;
        end
        req = 8'h80;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd7 || gnt_vld !== 1'b1) begin
            $display("FAIL fixed_top cyc=%0d got vld=%0b idx=%0d want vld=1 idx=7", cyc, gnt_vld, gnt_idx);
            n_err++;
        end
    endtask

    task automatic test_rr_fairness();
        mode = 1'b1; req = 8'hFF; gnt_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec() || gnt_vld !== 1'b1 || gnt_idx !== W'(k % N)) begin
                $display("FAIL rr_seq cyc=%0d got vld=%0b idx=%0d want vld=1 idx=%0d", cyc, gnt_vld, gnt_idx, k % N);
                n_err++;
            end
        end
    endtask

    task automatic test_backpressure();
        req = 8'h00; gnt_rdy = 1'b1;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_vld !== 1'b0) begin
            $display("FAIL drain_idle cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            n_err++;
        end
        mode = 1'b1; req = 8'b0001_0010; gnt_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req = 8'h00;
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec() || gnt_vld !== 1'b1 || gnt_idx !== 3'd1) begin
                $display("FAIL bp_hold cyc=%0d got vld=%0b idx=%0d want vld=1 idx=1", cyc, gnt_vld, gnt_idx);
                n_err++;
            end
        end
        gnt_rdy = 1'b1;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_vld !== 1'b0 || gnt_oh !== 8'h00) begin
            $display("FAIL bp_release cyc=%0d got vld=%0b oh=%h want vld=0 oh=00", cyc, gnt_vld, gnt_oh);
            n_err++;
        end
        // The pointer should now be 2. An all-ones request from idle must therefore grant index 2.
        req = 8'hFF; gnt_rdy = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd2) begin
            $display("FAIL bp_ptr cyc=%0d got idx=%0d want 2", cyc, gnt_idx);
            n_err++;
        end
        req = 8'h00; gnt_rdy = 1'b1;
        step();
    endtask

    task automatic test_wrap5();
        int want;
        n_cmp++;
        if ({gnt_vld5, gnt_idx5, gnt_oh5, gnt_pend5} !== '0) begin
            $display("FAIL n5_reset cyc=%0d got vld=%0b idx=%0d oh=%h pend=%0d want all 0",
                     cyc, gnt_vld5, gnt_idx5, gnt_oh5, gnt_pend5);
            n_err++;
        end
        rst_n5 = 1'b1; req5 = 5'b10001; mode5 = 1'b1; gnt_rdy5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            want = (k % 2 == 0) ? 0 : 4;
            n_cmp++;
            if (gnt_vld5 !== 1'b1 || gnt_idx5 !== W5'(want) || gnt_idx5 >= W5'(N5) ||
                gnt_oh5 !== (N5'(1) << want) || gnt_pend5 !== 4'd2) begin
                $display("FAIL n5_wrap cyc=%0d got vld=%0b idx=%0d oh=%h pend=%0d want vld=1 idx=%0d pend=2",
                         cyc, gnt_vld5, gnt_idx5, gnt_oh5, gnt_pend5, want);
                n_err++;
            end
        end
        rst_n5 = 1'b0;
    endtask

    task automatic test_mid_reset();
        mode = 1'b0; gnt_rdy = 1'b0;
`ifdef PRIO_ARB_MASK_EN
        req = 8'h0C; req_mask = 8'h04;
`else
        req = 8'h08;
`endif
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd3 || gnt_pend !== 4'd1 || gnt_vld !== 1'b1) begin
            $display("FAIL masked_grant cyc=%0d got vld=%0b idx=%0d pend=%0d want vld=1 idx=3 pend=1",
                     cyc, gnt_vld, gnt_idx, gnt_pend);
            n_err++;
        end
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== '0) begin
            $display("FAIL reset_mid_grant cyc=%0d got %h want 0", cyc, obs_vec());
            n_err++;
        end
        rst_n = 1'b1; mode = 1'b1; req = 8'hFF; req_mask = '0;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
            $display("FAIL restart_ptr0 cyc=%0d got vld=%0b idx=%0d want vld=1 idx=0", cyc, gnt_vld, gnt_idx);
            n_err++;
        end
`ifdef PRIO_ARB_MASK_EN
        req_mask = 8'h01;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
            $display("FAIL mask_no_retract cyc=%0d got vld=%0b idx=%0d want vld=1 idx=0", cyc, gnt_vld, gnt_idx);
            n_err++;
        end
        req_mask = 8'hFF; gnt_rdy = 1'b1;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt_vld !== 1'b0) begin
            $display("FAIL full_mask_idle cyc=%0d got vld=%0b want 0", cyc, gnt_vld);
            n_err++;
        end
        req_mask = '0;
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 39) != 0);
            req     = ($urandom_range(0, 5) == 0) ? 8'h00 : N'($urandom);
            mode    = 1'($urandom);
            gnt_rdy = ($urandom_range(0, 3) != 0);
`ifdef PRIO_ARB_MASK_EN
            req_mask = N'($urandom) & N'($urandom);
`endif
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random cyc=%0d req=%h mode=%0b rdy=%0b got {vld,idx,oh,pend}=%h want %h",
                         cyc, req, mode, gnt_rdy, obs_vec(), exp_vec());
                n_err++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_mask = '0; mode = 1'b0; gnt_rdy = 1'b0;
        rst_n5 = 1'b0; req5 = '0; req_mask5 = '0; mode5 = 1'b0; gnt_rdy5 = 1'b0;
        m_busy = 1'b0; m_idx = 0; m_pend = 0; m_ptr = 0;

        test_reset();
        test_fixed();
        test_rr_fairness();
        test_backpressure();
        test_wrap5();
        test_mid_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
